mem_stage: RTL

Data-memory access stage of the 5-stage RV32I pipeline, sitting directly downstream of the EX/MEM pipeline register and ending at the MEM/WB boundary. It turns load and store requests into a single-outstanding request/ready data bus transaction with byte enables. It sign- or zero-extends load data and registers the writeback fields. While an access is in flight it stalls the upstream pipeline, and it flags misaligned, illegal or timed-out accesses.

---
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Data-memory access stage of the RV32I pipeline: single-outstanding request/ready bus
// master with byte lanes, load extension, fault detection and the MEM/WB register.
module mem_stage #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  mem_size_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_out,
    output logic [31:0] wb_pc_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_rd_out,
    output logic        wb_reg_write_out,
    output logic        mem_err_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [15:0] TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);

    logic [0:0]  state;
    logic [15:0] timeout_cnt;
    logic [31:0] lat_pc;
    logic [4:0]  lat_rd;
    logic        lat_reg_write;
    logic [2:0]  lat_size;
    logic [1:0]  lat_addr_lo;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic        fault;
    logic        accept;
    logic        timeout_hit;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    // Decode legality of the access currently at the EX/MEM outputs.
    always_comb begin
        access     = mem_read_in | mem_write_in;
        illegal    = (mem_read_in & mem_write_in)
                   | (mem_size_in == 3'b011) | (mem_size_in == 3'b110) | (mem_size_in == 3'b111)
                   | (mem_write_in & mem_size_in[2]);
        misaligned = ((mem_size_in[1:0] == 2'b01) & alu_result_in[0])
                   | ((mem_size_in[1:0] == 2'b10) & (alu_result_in[1:0] != 2'b00));
        fault      = access & (illegal | misaligned);
        accept     = access & ~fault;
    end

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = rs2_data_in;
        case (mem_size_in[1:0])
            2'b00: begin
                store_be    = 4'b0001 << alu_result_in[1:0];
                store_wdata = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << {alu_result_in[1], 1'b0};
                store_wdata = {2{rs2_data_in[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = rs2_data_in;
            end
        endcase
    end

    // Aligned halves have addr[0]=0, so one shift brings either lane width down to bit 0.
    always_comb begin
        rdata_shifted = dmem_rdata >> {lat_addr_lo, 3'b000};
        case (lat_size[1:0])
            2'b00:   load_data = {{24{~lat_size[2] & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_data = {{16{~lat_size[2] & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        timeout_hit = (state == ST_BUSY) & ~dmem_ready & (timeout_cnt == TIMEOUT_LAST);
        if (state == ST_IDLE) begin
            stall_out = accept;
        end else begin
            stall_out = ~dmem_ready & ~timeout_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            timeout_cnt      <= '0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            dmem_be          <= '0;
            lat_pc           <= '0;
            lat_rd           <= '0;
            lat_reg_write    <= 1'b0;
            lat_size         <= '0;
            lat_addr_lo      <= '0;
            wb_pc_out        <= '0;
            wb_data_out      <= '0;
            wb_rd_out        <= '0;
            wb_reg_write_out <= 1'b0;
            mem_err_out      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wb_pc_out <= pc_in;
                    wb_rd_out <= rd_in;
                    if (fault) begin
                        wb_data_out      <= '0;
                        wb_reg_write_out <= 1'b0;
                        mem_err_out      <= 1'b1;
                    end else if (accept) begin
                        wb_data_out      <= '0;
                        wb_reg_write_out <= 1'b0;
                        mem_err_out      <= 1'b0;
                        lat_pc           <= pc_in;
                        lat_rd           <= rd_in;
                        lat_reg_write    <= reg_write_in;
                        lat_size         <= mem_size_in;
                        lat_addr_lo      <= alu_result_in[1:0];
                        dmem_req         <= 1'b1;
                        dmem_we          <= mem_write_in;
                        dmem_addr        <= {alu_result_in[31:2], 2'b00};
                        dmem_wdata       <= store_wdata;
                        dmem_be          <= store_be;
                        timeout_cnt      <= '0;
                        state            <= ST_BUSY;
                    end else begin
                        wb_data_out      <= alu_result_in;
                        wb_reg_write_out <= reg_write_in;
                        mem_err_out      <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    wb_pc_out <= lat_pc;
                    wb_rd_out <= lat_rd;
                    if (dmem_ready) begin
                        wb_data_out      <= dmem_we ? 32'd0 : load_data;
                        wb_reg_write_out <= lat_reg_write & ~dmem_we;
                        mem_err_out      <= 1'b0;
                        dmem_req         <= 1'b0;
                        state            <= ST_IDLE;
                    end else if (timeout_hit) begin
                        wb_data_out      <= '0;
                        wb_reg_write_out <= 1'b0;
                        mem_err_out      <= 1'b1;
                        dmem_req         <= 1'b0;
                        state            <= ST_IDLE;
                    end else begin
                        wb_data_out      <= '0;
                        wb_reg_write_out <= 1'b0;
                        mem_err_out      <= 1'b0;
                        timeout_cnt      <= timeout_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
